// File: rtl/rom_init_pkg.sv
// Shared state encoding and default masking constants for the ROM initiator.
package rom_init_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        READ     = 3'd2,
        CMP_LAST = 3'd3,
        DONE     = 3'd4
    } rom_state_t;

    localparam logic [7:0] DEF_MASK = 8'h5F;
    localparam logic [7:0] DEF_DEFU = 8'hFF;

endpackage

// File: rtl/rom_expect_gen.sv
// Seeded pattern generator: raw pattern P(addr) and the value the masked memory should hold.
module rom_expect_gen #(
    parameter int DW = 8,
    parameter int AW = 4,
    parameter logic [DW-1:0] MASK = 8'h5F,
    parameter logic [DW-1:0] DEFU = 8'hFF
) (
    input  logic [DW-1:0] seed,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] pat,
    output logic [DW-1:0] exp
);

    assign pat = seed + DW'(addr);
    assign exp = (pat & MASK) | (DEFU & ~MASK);

endmodule

// File: rtl/rom_initiator.sv
// Fill/readback sequencer for the masked 16x8 memory.
// Optional FAIL_CAPTURE_EN adds fail_addr/fail_data capture of the first mismatch.
//
//  state    | meaning
//  IDLE     | waiting for start
//  WRITE    | writing P(a) to addresses 0..DEP-1
//  READ     | reading addresses 0..DEP-1, compare lags one cycle
//  CMP_LAST | compare of the final read address
//  DONE     | publish done/pass, drop busy
module rom_initiator
    import rom_init_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4,
    parameter int DEP = 16,
    parameter logic [DW-1:0] MASK = DEF_MASK,
    parameter logic [DW-1:0] DEFU = DEF_DEFU
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          op,
    input  logic [DW-1:0] seed,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          pass,
`ifdef FAIL_CAPTURE_EN
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
`endif
    output logic [AW:0]   err_cnt
);

    localparam logic [AW-1:0] LAST = AW'(DEP - 1);

    rom_state_t    state, state_nxt;
    logic [AW-1:0] addr, addr_q;
    logic [DW-1:0] seed_q, rdata_q;
    logic          cmp_vld, mis;
    logic [DW-1:0] pat_wr, exp_wr, pat_cmp, exp_cmp;
    logic          unused_gen;

    rom_expect_gen #(.DW(DW), .AW(AW), .MASK(MASK), .DEFU(DEFU)) u_gen_wr (
        .seed (seed_q),
        .addr (addr),
        .pat  (pat_wr),
        .exp  (exp_wr)
    );

    rom_expect_gen #(.DW(DW), .AW(AW), .MASK(MASK), .DEFU(DEFU)) u_gen_cmp (
        .seed (seed_q),
        .addr (addr_q),
        .pat  (pat_cmp),
        .exp  (exp_cmp)
    );

    assign unused_gen = ^{exp_wr, pat_cmp};

    assign mem_wr   = (state == WRITE);
    assign mem_addr = (state == WRITE || state == READ) ? addr : '0;
    assign mem_data = (state == WRITE) ? pat_wr : '0;
    assign mis      = cmp_vld && (rdata_q != exp_cmp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = op ? READ : WRITE;
            WRITE:    if (addr == LAST) state_nxt = READ;
            READ:     if (addr == LAST) state_nxt = CMP_LAST;
            CMP_LAST: state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr    <= '0;
            addr_q  <= '0;
            seed_q  <= '0;
            rdata_q <= '0;
            cmp_vld <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
        end else begin
            done    <= 1'b0;
            addr_q  <= addr;
            rdata_q <= mem_rdata;
            cmp_vld <= (state == READ);
            if (mis) err_cnt <= err_cnt + (AW+1)'(1);
            case (state)
                IDLE: if (start) begin
                    seed_q  <= seed;
                    err_cnt <= '0;
                    busy    <= 1'b1;
                    pass    <= 1'b0;
                    addr    <= '0;
                end
                WRITE: addr <= (addr == LAST) ? '0 : addr + AW'(1);
                // READ holds the last address instead of wrapping
                READ:  if (addr != LAST) addr <= addr + AW'(1);
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (err_cnt == '0);
                    addr <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef FAIL_CAPTURE_EN
    logic fail_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_seen <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (state == IDLE && start) begin
            fail_seen <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (mis && !fail_seen) begin
            fail_seen <= 1'b1;
            fail_addr <= addr_q;
            fail_data <= rdata_q;
        end
    end
`endif

endmodule

// File: tb/tb_rom_initiator.sv
// Directed bench for rom_initiator with a behavioural masked 16x8 memory.
module tb_rom_initiator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] seed = 8'h00;
    logic       mem_wr;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] mem_rdata;
    logic       busy, done, pass;
    logic [4:0] err_cnt;
`ifdef FAIL_CAPTURE_EN
    logic [3:0] fail_addr;
    logic [7:0] fail_data;
`endif

    logic [7:0] mem [16];
    logic [7:0] wlog [16];
    int         wr_cnt = 0;
    logic       pre_fill = 1'b0;
    logic       corrupt = 1'b0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         lat;
    int         wr_base;

    always #5 clk = ~clk;

    rom_initiator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .seed      (seed),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
`ifdef FAIL_CAPTURE_EN
        .fail_addr (fail_addr),
        .fail_data (fail_data),
`endif
        .err_cnt   (err_cnt)
    );

    // memory masks on write: bits 7 and 5 forced to 1
    always @(posedge clk) begin
        if (pre_fill) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h11;
        end else if (mem_wr) begin
            mem[mem_addr] <= (mem_data & 8'h5F) | 8'hA0;
        end
    end

    always_comb begin
        mem_rdata = mem[mem_addr];
        if (corrupt && (mem_addr == 4'd3 || mem_addr == 4'd9)) mem_rdata = 8'h00;
    end

    always @(negedge clk) begin
        if (mem_wr) begin
            wlog[mem_addr] = mem_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic run_cmd(input bit op_i, input logic [7:0] seed_i, input bit pulse, output int lat_o);
        @(negedge clk);
        op = op_i;
        seed = seed_i;
        start = 1'b1;
        lat_o = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat_o++;
            if (lat_o == 1) begin
                start = 1'b0;
                chk("busy_rise", busy, 1);
                chk("err_clr", err_cnt, 0);
            end
            if (pulse && lat_o == 5) begin
                start = 1'b1;
                seed = 8'h55;
                op = 1'b0;
            end
            if (pulse && lat_o == 6) start = 1'b0;
            if (done) break;
        end
        chk("done_seen", done, 1);
        chk("busy_fall", busy, 0);
    endtask

    initial begin
        // reset state
        pre_fill = 1'b1;
        #12;
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        @(negedge clk);
        pre_fill = 1'b0;
        rst_n = 1'b1;

        // Test 1: reset while writing address 5
        @(negedge clk);
        op = 1'b0;
        seed = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_wr && mem_addr == 4'd5) break;
            @(negedge clk);
        end
        chk("t1_at_addr5", mem_addr, 5);
        rst_n = 1'b0;
        #1;
        chk("t1_busy", busy, 0);
        chk("t1_mem_wr", mem_wr, 0);
        repeat (2) @(negedge clk);
        chk("t1_mem0", mem[0], 8'hA0);
        chk("t1_mem4", mem[4], 8'hA4);
        chk("t1_mem5", mem[5], 8'h11);
        chk("t1_mem15", mem[15], 8'h11);
        rst_n = 1'b1;

        // Test 2: fill+check, seed 0x00
        wr_base = wr_cnt;
        run_cmd(1'b0, 8'h00, 1'b0, lat);
        chk("t2_lat", lat, 35);
        chk("t2_pass", pass, 1);
        chk("t2_err", err_cnt, 0);
        chk("t2_wr_cnt", wr_cnt - wr_base, 16);
        chk("t2_wdata0", wlog[0], 8'h00);
        chk("t2_wdata9", wlog[9], 8'h09);
        chk("t2_wdata15", wlog[15], 8'h0F);
        chk("t2_mem7", mem[7], 8'hA7);
        chk("t2_mem15", mem[15], 8'hAF);
        @(posedge clk);
        #1;
        chk("t2_done_pulse", done, 0);
        chk("t2_pass_hold", pass, 1);

        // Test 4: check only, corrupted reads at 3 and 9
        corrupt = 1'b1;
        wr_base = wr_cnt;
        run_cmd(1'b1, 8'h00, 1'b0, lat);
        chk("t4_lat", lat, 19);
        chk("t4_err", err_cnt, 2);
        chk("t4_pass", pass, 0);
        chk("t4_no_write", wr_cnt - wr_base, 0);
`ifdef FAIL_CAPTURE_EN
        chk("t4_fail_addr", fail_addr, 3);
        chk("t4_fail_data", fail_data, 8'h00);
`endif
        corrupt = 1'b0;

        // Test 5: second start mid-command is ignored
        wr_base = wr_cnt;
        run_cmd(1'b1, 8'h00, 1'b1, lat);
        chk("t5_lat", lat, 19);
        chk("t5_err", err_cnt, 0);
        chk("t5_pass", pass, 1);
        chk("t5_no_write", wr_cnt - wr_base, 0);
`ifdef FAIL_CAPTURE_EN
        chk("t5_fail_addr", fail_addr, 0);
        chk("t5_fail_data", fail_data, 8'h00);
`endif

        // Test 3: fill+check, seed 0xF0
        run_cmd(1'b0, 8'hF0, 1'b0, lat);
        chk("t3_lat", lat, 35);
        chk("t3_pass", pass, 1);
        chk("t3_err", err_cnt, 0);
        chk("t3_wdata15", wlog[15], 8'hFF);
        chk("t3_mem0", mem[0], 8'hF0);
        chk("t3_mem15", mem[15], 8'hFF);

        // Test 6: back-to-back check with seed 0x00 against 0xF0 contents
        run_cmd(1'b1, 8'h00, 1'b0, lat);
        chk("t6_lat", lat, 19);
        chk("t6_err", err_cnt, 16);
        chk("t6_pass", pass, 0);
`ifdef FAIL_CAPTURE_EN
        chk("t6_fail_addr", fail_addr, 0);
        chk("t6_fail_data", fail_data, 8'hF0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
